// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// trained from the EX-stage resolved outcome; also raises flush/redirect on mispredict.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_pc_f,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_pc,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = XLEN - IDX - 2;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr     [ENTRIES];
  logic [TW-1:0]      tag_mem [ENTRIES];
  logic [XLEN-1:0]    tgt_mem [ENTRIES];

  logic [IDX-1:0] idx_f, idx_ex;
  logic [TW-1:0]  tag_f, tag_ex;
  logic           hit_f, hit_ex;
  logic           upd, mispredict;

  assign idx_f  = pc_f[IDX+1:2];
  assign tag_f  = pc_f[XLEN-1:IDX+2];
  assign idx_ex = ex_pc[IDX+1:2];
  assign tag_ex = ex_pc[XLEN-1:IDX+2];

  // Lookup reads pre-update contents; valid clears asynchronously so reset forces a miss.
  assign hit_f        = valid[idx_f] && (tag_mem[idx_f] == tag_f);
  assign pred_taken_f = hit_f && ctr[idx_f][1];
  assign pred_pc_f    = pred_taken_f ? tgt_mem[idx_f] : pc_f + XLEN'(4);

  assign hit_ex     = valid[idx_ex] && (tag_mem[idx_ex] == tag_ex);
  assign upd        = ex_valid && ex_is_branch;
  assign mispredict = (ex_br_taken != ex_pred_taken) ||
                      (ex_br_taken && (ex_pred_pc != ex_target));

  assign flush = rst_n && upd && mispredict;

  always_comb begin
    redirect_pc = ex_pc + XLEN'(4);
    if (!rst_n)
      redirect_pc = '0;
    else if (flush && ex_br_taken)
      redirect_pc = ex_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid         <= '0;
      br_count      <= '0;
      mispred_count <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr[i] <= 2'b01;
    end else if (upd) begin
      br_count <= br_count + 32'd1;
      if (mispredict)
        mispred_count <= mispred_count + 32'd1;
      if (ex_br_taken) begin
        valid[idx_ex] <= 1'b1;
        if (!hit_ex)
          ctr[idx_ex] <= 2'b10;
        else if (ctr[idx_ex] != 2'b11)
          ctr[idx_ex] <= ctr[idx_ex] + 2'd1;
      end else if (hit_ex && (ctr[idx_ex] != 2'b00)) begin
        ctr[idx_ex] <= ctr[idx_ex] - 2'd1;
      end
    end
  end

  // Tag/target need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (rst_n && upd && ex_br_taken) begin
      tag_mem[idx_ex] <= tag_ex;
      tgt_mem[idx_ex] <= ex_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expected lookup/resolve results are queued
// when stimulus is driven and compared at the following falling edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_pc_f;
  logic        ex_valid, ex_is_branch, ex_br_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_pc;
  logic        flush;
  logic [31:0] redirect_pc, br_count, mispred_count;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        pt;
    logic [31:0] ppc;
    logic        fl;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_f          (pc_f),
    .pred_taken_f  (pred_taken_f),
    .pred_pc_f     (pred_pc_f),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .ex_pc         (ex_pc),
    .ex_br_taken   (ex_br_taken),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_pc    (ex_pred_pc),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus from posedge+1, compare at the following negedge.
  task automatic step(input logic [31:0] pc, input logic v, input logic b,
                      input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                      input logic ppt, input logic [31:0] pppc,
                      input logic ept, input logic [31:0] eppc,
                      input logic efl, input logic [31:0] erd);
    exp_t e;
    pc_f          = pc;
    ex_valid      = v;
    ex_is_branch  = b;
    ex_pc         = epc;
    ex_br_taken   = tk;
    ex_target     = tgt;
    ex_pred_taken = ppt;
    ex_pred_pc    = pppc;
    exp_q.push_back('{pt: ept, ppc: eppc, fl: efl, rd: erd});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("pred_taken_f", {31'd0, pred_taken_f}, {31'd0, e.pt});
      chk("pred_pc_f", pred_pc_f, e.ppc);
      chk("flush", {31'd0, flush}, {31'd0, e.fl});
      chk("redirect_pc", redirect_pc, e.rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] pc, input logic ept, input logic [31:0] eppc);
    step(pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, ept, eppc, 1'b0, 32'h4);
  endtask

  task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                    input logic ppt, input logic [31:0] pppc,
                    input logic ept, input logic [31:0] eppc,
                    input logic efl, input logic [31:0] erd);
    step(pc, 1'b1, 1'b1, pc, tk, tgt, ppt, pppc, ept, eppc, efl, erd);
  endtask

  task automatic cnt(input logic [31:0] b, input logic [31:0] m);
    chk("br_count", br_count, b);
    chk("mispred_count", mispred_count, m);
  endtask

  initial begin
    rst_n = 1'b0;
    pc_f = 32'h100;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h100;
    ex_br_taken = 1'b1; ex_target = 32'h80;
    ex_pred_taken = 1'b0; ex_pred_pc = 32'h104;
    #3;
    chk("rst_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("rst_pred_pc", pred_pc_f, 32'h104);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'h0);
    cnt(32'd0, 32'd0);
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'h0;
    ex_br_taken = 1'b0; ex_target = 32'h0; ex_pred_pc = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // cold start and first taken branch
    idle(32'h100, 1'b0, 32'h104);
    br(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80);
    cnt(32'd1, 32'd1);
    br(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h104);
    br(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h104);
    cnt(32'd3, 32'd1);
    br(32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    cnt(32'd4, 32'd2);
    idle(32'h100, 1'b1, 32'h80);

    // back to 11, then four not-taken saturate at 00, one taken gives 01
    br(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h104);
    br(32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    br(32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    idle(32'h100, 1'b0, 32'h104);
    br(32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104);
    br(32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104);
    cnt(32'd9, 32'd4);
    br(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80);
    idle(32'h100, 1'b0, 32'h104);
    cnt(32'd10, 32'd5);

    // target mismatch on a correctly predicted taken branch
    br(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80);
    idle(32'h100, 1'b1, 32'h80);
    br(32'h100, 1'b1, 32'hC0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'hC0);
    idle(32'h100, 1'b1, 32'hC0);
    cnt(32'd12, 32'd7);

    // aliasing index and same-cycle read/write
    idle(32'h200, 1'b0, 32'h204);
    br(32'h200, 1'b1, 32'h300, 1'b0, 32'h204, 1'b0, 32'h204, 1'b1, 32'h300);
    idle(32'h200, 1'b1, 32'h300);
    idle(32'h100, 1'b0, 32'h104);
    cnt(32'd13, 32'd8);

    // squashed or non-branch EX instruction: no flush, no training
    step(32'h200, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 32'h204);
    step(32'h200, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 32'h204);
    idle(32'h200, 1'b1, 32'h300);
    cnt(32'd13, 32'd8);
    idle(32'hFFFF_FFFC, 1'b0, 32'h0);

    // asynchronous reset between edges while an update is pending
    pc_f = 32'h200;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h200;
    ex_br_taken = 1'b0; ex_target = 32'h0;
    ex_pred_taken = 1'b1; ex_pred_pc = 32'h300;
    #1;
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    chk("pre_rst_pred", {31'd0, pred_taken_f}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_flush", {31'd0, flush}, 32'd0);
    chk("async_redirect", redirect_pc, 32'h0);
    chk("async_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("async_pred_pc", pred_pc_f, 32'h204);
    cnt(32'd0, 32'd0);
    @(posedge clk);
    #1;
    cnt(32'd0, 32'd0);
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'h0;
    ex_pred_taken = 1'b0; ex_pred_pc = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(32'h200, 1'b0, 32'h204);
    idle(32'h100, 1'b0, 32'h104);
    cnt(32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor with branch target buffer (BTB).
- Supplies a predicted next PC to IF each cycle.
- Is trained in EX by the resolved branch_taken outcome from the execute-stage branch comparator.
- Raises a flush/redirect when the resolved outcome or target disagrees with the prediction carried down the pipe.

Parameters:
- ENTRIES, 64, number of BTB/counter entries; power of two, ≥4.
- XLEN, 32, address width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_f  input  XLEN  fetch PC, word aligned.
- pred_taken_f  output  1  prediction for pc_f.
- pred_pc_f  output  XLEN  predicted next PC for pc_f.
- ex_valid  input  1  EX stage holds a live instruction (not bubble/flushed).
- ex_is_branch  input  1  EX instruction is a conditional branch.
- ex_pc  input  XLEN  PC of EX instruction.
- ex_br_taken  input  1  resolved outcome from comparator.
- ex_target  input  XLEN  computed branch target (pc+imm).
- ex_pred_taken  input  1  pred_taken_f piped along with the instruction.
- ex_pred_pc  input  XLEN  pred_pc_f piped along with the instruction.
- flush  output  1  mispredict: kill IF/ID, redirect fetch.
- redirect_pc  output  XLEN  correct next PC when flush=1.
- br_count  output  32  resolved branches since reset.
- mispred_count  output  32  mispredicts since reset.

Behaviour:
- IDX = log2(ENTRIES).
- index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
- Per entry: valid bit, tag, target (XLEN), 2-bit saturating counter.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.

Reset (asynchronous, rst_n=0):
- All valid=0, counters=01, br_count=0, mispred_count=0.
- Tags/targets may remain unreset.
- Outputs during reset: pred_taken_f=0, pred_pc_f=pc_f+4, flush=0, redirect_pc=0.

Lookup (combinational, 0-cycle latency from pc_f):
- hit = valid[index] && tag match.
- pred_taken_f = hit && counter[1].
- pred_pc_f = pred_taken_f ? target[index] : pc_f+4 (mod 2^XLEN, wraps).

Resolve (combinational, when upd = ex_valid && ex_is_branch):
- Mispredict if:
  - ex_br_taken != ex_pred_taken, or
  - ex_br_taken && ex_pred_pc != ex_target.
- flush = upd && mispredict.
- redirect_pc = ex_br_taken ? ex_target : ex_pc+4.
- When flush=0: redirect_pc = ex_pc+4 (don't-care, but deterministic).
- Non-branch or ex_valid=0: no flush, no training, counters unchanged.

Training (registered, on the clock edge after upd):
- Taken:
  - counter saturating +1 (11 stays 11).
  - valid=1, tag and target written.
  - On tag mismatch (replacement): counter set to 10.
- Not taken:
  - With hit: counter saturating -1 (00 stays 00).
  - With miss: no allocation, entry unchanged.

Perf counters (registered, on upd):
- br_count +1.
- mispred_count +1 when mispredict.
- Both wrap at 2^32.

Simultaneous events:
- Lookup and training of the same index in one cycle: lookup sees the pre-update contents (no bypass).
- New value is visible the next cycle.

Reset mid-operation:
- Asserting rst_n=0 with upd=1 discards the update.
- All state returns to reset values immediately, without waiting for a clock edge.

Test Plan:
- Cold start: after reset, pc_f=0x0000_0100 -> pred_taken_f=0, pred_pc_f=0x0000_0104; flush=0.
- First taken branch, then repeats:
  - Stimulus: upd at ex_pc=0x100, ex_br_taken=1, ex_target=0x080, ex_pred_taken=0.
  - Same cycle: flush=1, redirect_pc=0x080, mispred_count=1.
  - Next cycle: pc_f=0x100 -> pred_taken_f=1, pred_pc_f=0x080.
  - Two more taken updates -> counter reaches 11.
  - One not-taken update (flush=1, redirect_pc=0x104) -> counter 10, still predicts taken at 0x080.
- Saturation:
  - 4 consecutive not-taken on a hit entry at 11 -> after the 2nd, pred_taken_f=0; counter stays 00.
  - Then one taken -> 01, still predicts not-taken.
- Target mismatch and aliasing:
  - Taken, correctly predicted, with ex_pred_pc=0x080 but ex_target=0x0C0 -> flush=1, redirect_pc=0x0C0; entry target updated.
  - PC 0x100 + ENTRIES*4 (same index, different tag) -> miss, pred_pc_f=pc+4.
- Same-cycle read/write:
  - Update entry for 0x200 while pc_f=0x200 -> that cycle shows old prediction; next cycle shows new.
  - ex_valid=0 with ex_is_branch=1 -> no flush, counters and br_count unchanged.
- Async reset mid-training:
  - Drop rst_n between clock edges during upd=1 -> outputs return to reset values immediately.
  - Prior entries are gone: lookup of a previously trained PC misses.
